// File: rtl/output_compare_misr_if.sv
// Bundles the stimulus/result signals of the identity-flow output checker.
// The master side drives the vector stream; the slave side is the checker.
interface output_compare_misr_if #(
  parameter int unsigned WIDTH = 233,
  parameter int unsigned SIG_W = 32,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             valid_in;
  logic             last_in;
  logic [WIDTH-1:0] y_ref;
  logic [WIDTH-1:0] y_dut;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_count;
  logic [CNT_W-1:0] first_mismatch_cycle;
  logic [7:0]       first_mismatch_bit;
  logic [SIG_W-1:0] signature_ref;
  logic [SIG_W-1:0] signature_dut;

  modport master (
    output start, valid_in, last_in, y_ref, y_dut,
    input  busy, done, pass, mismatch_count, first_mismatch_cycle,
           first_mismatch_bit, signature_ref, signature_dut
  );

  modport slave (
    input  start, valid_in, last_in, y_ref, y_dut,
    output busy, done, pass, mismatch_count, first_mismatch_cycle,
           first_mismatch_bit, signature_ref, signature_dut
  );
endinterface

// File: rtl/output_compare_misr.sv
// Compares reference and netlist output streams: counts mismatches, records the
// first one, and compresses each stream into a MISR signature.
module output_compare_misr #(
  parameter int unsigned     WIDTH = 233,
  parameter int unsigned     SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
  parameter int unsigned     CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst,
  output_compare_misr_if.slave  bus
);

  localparam int unsigned NSLICE = (WIDTH + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W  = NSLICE * SIG_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] diff;
  logic [7:0]       low_bit;

  logic [SIG_W-1:0] sig_ref_q, sig_ref_nxt;
  logic [SIG_W-1:0] sig_dut_q, sig_dut_nxt;
  logic [CNT_W-1:0] mcnt_q, mcnt_nxt;
  logic [CNT_W-1:0] fcyc_q, fcyc_nxt;
  logic [7:0]       fbit_q, fbit_nxt;
  logic [CNT_W-1:0] cidx_q, cidx_nxt;
  logic             busy_q, done_q, pass_q;

  function automatic logic [SIG_W-1:0] fold(input logic [WIDTH-1:0] v);
    logic [PAD_W-1:0] padded;
    logic [SIG_W-1:0] acc;
    padded = PAD_W'(v);
    acc    = '0;
    for (int s = 0; s < int'(NSLICE); s++) acc ^= padded[s*SIG_W +: SIG_W];
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] f);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ f;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A start in any state (re)opens a run; the start-cycle vector is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (bus.start) state_nxt = RUN;
               else if (bus.valid_in && bus.last_in) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == RUN) && bus.valid_in && !bus.start;
  assign diff   = bus.y_ref ^ bus.y_dut;

  // Lowest differing bit: scan downward so the smallest index wins.
  always_comb begin
    low_bit = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (diff[i]) low_bit = 8'(i);
    end
  end

  always_comb begin
    sig_ref_nxt = sig_ref_q;
    sig_dut_nxt = sig_dut_q;
    mcnt_nxt    = mcnt_q;
    fcyc_nxt    = fcyc_q;
    fbit_nxt    = fbit_q;
    cidx_nxt    = cidx_q;
    if (bus.start) begin
      sig_ref_nxt = '0;
      sig_dut_nxt = '0;
      mcnt_nxt    = '0;
      fcyc_nxt    = '1;
      fbit_nxt    = '1;
      cidx_nxt    = '0;
    end else if (accept) begin
      sig_ref_nxt = misr_step(sig_ref_q, fold(bus.y_ref));
      sig_dut_nxt = misr_step(sig_dut_q, fold(bus.y_dut));
      if (diff != '0) begin
        if (mcnt_q == '0) begin
          fcyc_nxt = cidx_q;
          fbit_nxt = low_bit;
        end
        if (mcnt_q != '1) mcnt_nxt = mcnt_q + CNT_W'(1);
      end
      if (cidx_q != '1) cidx_nxt = cidx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_ref_q <= '0;
      sig_dut_q <= '0;
      mcnt_q    <= '0;
      fcyc_q    <= '1;
      fbit_q    <= '1;
      cidx_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      sig_ref_q <= sig_ref_nxt;
      sig_dut_q <= sig_dut_nxt;
      mcnt_q    <= mcnt_nxt;
      fcyc_q    <= fcyc_nxt;
      fbit_q    <= fbit_nxt;
      cidx_q    <= cidx_nxt;
      busy_q    <= (state_nxt == RUN);
      done_q    <= (state_nxt == DONE);
      pass_q    <= (state_nxt == DONE) && (mcnt_nxt == '0);
    end
  end

  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.pass                 = pass_q;
  assign bus.mismatch_count       = mcnt_q;
  assign bus.first_mismatch_cycle = fcyc_q;
  assign bus.first_mismatch_bit   = fbit_q;
  assign bus.signature_ref        = sig_ref_q;
  assign bus.signature_dut        = sig_dut_q;

endmodule

// File: tb/tb_output_compare_misr.sv
// Scoreboard bench for output_compare_misr: a behavioural model predicts every
// cycle's outputs, which are queued on drive and compared after the clock edge.
module tb_output_compare_misr;

  localparam int unsigned W  = 233;
  localparam logic [31:0] PL = 32'h04C11DB7;

  typedef struct {
    logic        busy, done, pass;
    logic [15:0] cnt, fcyc;
    logic [7:0]  fbit;
    logic [31:0] sref, sdut;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // model state: 0 idle, 1 run, 2 done
  int          m_st;
  logic [31:0] m_sref, m_sdut;
  logic [15:0] m_cnt, m_fcyc, m_idx;
  logic [7:0]  m_fbit;

  output_compare_misr_if #(.WIDTH(233), .SIG_W(32), .CNT_W(16)) bus ();

  output_compare_misr #(.WIDTH(233), .SIG_W(32), .POLY(PL), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_fold(input logic [W-1:0] v);
    logic [31:0] f = '0;
    for (int i = 0; i < int'(W); i++) f[i % 32] ^= v[i];
    return f;
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [31:0] f);
    logic [31:0] n = s << 1;
    if (s[31]) n ^= PL;
    return n ^ f;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v = '0;
    for (int k = 0; k < 8; k++) v |= W'($urandom) << (32 * k);
    return v;
  endfunction

  task automatic m_reset();
    m_st = 0; m_sref = '0; m_sdut = '0; m_cnt = '0;
    m_fcyc = 16'hFFFF; m_fbit = 8'hFF; m_idx = '0;
  endtask

  task automatic m_update(input logic st, input logic v, input logic l,
                          input logic [W-1:0] r, input logic [W-1:0] d);
    logic [W-1:0] df;
    if (st) begin
      m_reset();
      m_st = 1;
    end else if (m_st == 1 && v) begin
      m_sref = m_misr(m_sref, m_fold(r));
      m_sdut = m_misr(m_sdut, m_fold(d));
      df = r ^ d;
      if (df != '0) begin
        if (m_cnt == 0) begin
          m_fcyc = m_idx;
          for (int i = 0; i < int'(W); i++) if (df[i]) begin m_fbit = 8'(i); break; end
        end
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (m_idx != 16'hFFFF) m_idx++;
      if (l) m_st = 2;
    end
  endtask

  function automatic exp_t m_exp();
    exp_t e;
    e.busy = (m_st == 1); e.done = (m_st == 2); e.pass = (m_st == 2) && (m_cnt == 0);
    e.cnt = m_cnt; e.fcyc = m_fcyc; e.fbit = m_fbit; e.sref = m_sref; e.sdut = m_sdut;
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, ".busy"}, 64'(bus.busy), 64'(e.busy));
    check({tag, ".done"}, 64'(bus.done), 64'(e.done));
    check({tag, ".pass"}, 64'(bus.pass), 64'(e.pass));
    check({tag, ".cnt"},  64'(bus.mismatch_count), 64'(e.cnt));
    check({tag, ".fcyc"}, 64'(bus.first_mismatch_cycle), 64'(e.fcyc));
    check({tag, ".fbit"}, 64'(bus.first_mismatch_bit), 64'(e.fbit));
    check({tag, ".sref"}, 64'(bus.signature_ref), 64'(e.sref));
    check({tag, ".sdut"}, 64'(bus.signature_dut), 64'(e.sdut));
  endtask

  task automatic step(input string tag, input logic st, input logic v, input logic l,
                      input logic [W-1:0] r, input logic [W-1:0] d);
    bus.start = st; bus.valid_in = v; bus.last_in = l; bus.y_ref = r; bus.y_dut = d;
    m_update(st, v, l, r, d);
    sb.push_back(m_exp());
    @(posedge clk);
    #1;
    compare_out(tag);
    bus.start = 1'b0; bus.valid_in = 1'b0; bus.last_in = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r, d, one;
    one = W'(1);
    bus.start = 1'b0; bus.valid_in = 1'b0; bus.last_in = 1'b0;
    bus.y_ref = '0; bus.y_dut = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(m_exp());
    compare_out("rst");
    #3 rst = 1'b0;

    // 1: 21 matching vectors, plus a stray last_in without valid_in
    step("t1.start", 1, 0, 0, '0, '0);
    for (int i = 0; i < 21; i++) begin
      r = rand_vec();
      if (i == 10) step("t1.lastnv", 0, 0, 1, r, r);
      step($sformatf("t1.v%0d", i), 0, 1, (i == 20), r, r);
    end
    check("t1.pass_const", 64'(bus.pass), 64'd1);

    // 2: two vectors of value 1
    step("t2.start", 1, 0, 0, '0, '0);
    step("t2.v0", 0, 1, 0, one, one);
    step("t2.v1", 0, 1, 1, one, one);
    check("t2.sref_const", 64'(bus.signature_ref), 64'h3);
    check("t2.sdut_const", 64'(bus.signature_dut), 64'h3);

    // 3: bit 40 flipped in vector 3 only
    step("t3.start", 1, 0, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      r = rand_vec(); d = r;
      if (i == 3) d[40] = ~d[40];
      step($sformatf("t3.v%0d", i), 0, 1, (i == 4), r, d);
    end
    check("t3.cnt_const", 64'(bus.mismatch_count), 64'd1);
    check("t3.fcyc_const", 64'(bus.first_mismatch_cycle), 64'd3);
    check("t3.fbit_const", 64'(bus.first_mismatch_bit), 64'd40);
    check("t3.pass_const", 64'(bus.pass), 64'd0);

    // 4: bits 7 and 200 in vector 0, bit 1 in vector 2
    step("t4.start", 1, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      r = rand_vec(); d = r;
      if (i == 0) begin d[7] = ~d[7]; d[200] = ~d[200]; end
      if (i == 2) d[1] = ~d[1];
      step($sformatf("t4.v%0d", i), 0, 1, (i == 3), r, d);
    end
    check("t4.fcyc_const", 64'(bus.first_mismatch_cycle), 64'd0);
    check("t4.fbit_const", 64'(bus.first_mismatch_bit), 64'd7);
    check("t4.cnt_const", 64'(bus.mismatch_count), 64'd2);

    // 5: async reset mid-run, ignored valid in IDLE, then clean run
    step("t5.start", 1, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      r = rand_vec(); d = rand_vec();
      step($sformatf("t5.v%0d", i), 0, 1, 0, r, d);
    end
    #2 rst = 1'b1;
    #1;
    m_reset();
    sb.push_back(m_exp());
    compare_out("t5.async_rst");
    #3 rst = 1'b0;
    r = rand_vec(); d = rand_vec();
    step("t5.idle_valid", 0, 1, 1, r, d);
    step("t5.restart", 1, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      r = rand_vec();
      step($sformatf("t5.c%0d", i), 0, 1, (i == 2), r, r);
    end
    check("t5.pass_const", 64'(bus.pass), 64'd1);

    // 6: start in RUN and in DONE discards that cycle's vector
    step("t6.start", 1, 0, 0, '0, '0);
    r = rand_vec(); d = ~r;
    step("t6.pre", 0, 1, 0, r, d);
    step("t6.run_start", 1, 1, 0, r, d);
    for (int i = 0; i < 3; i++) begin
      r = rand_vec(); d = r;
      if (i == 1) d[232] = ~d[232];
      step($sformatf("t6.v%0d", i), 0, 1, (i == 2), r, d);
    end
    r = rand_vec(); d = ~r;
    step("t6.after_done", 0, 1, 1, r, d);
    check("t6.cnt_const", 64'(bus.mismatch_count), 64'd1);
    check("t6.fbit_const", 64'(bus.first_mismatch_bit), 64'd232);
    step("t6.done_start", 1, 1, 1, r, d);
    check("t6.cleared_cnt", 64'(bus.mismatch_count), 64'd0);
    r = rand_vec();
    step("t6.w0", 0, 1, 1, r, r);
    check("t6.pass2_const", 64'(bus.pass), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
